// File: rtl/mem_access_if.sv
// Data-memory port between the MEM stage and the data memory.
// Single outstanding access; a request completes in the cycle ready is high.
interface mem_access_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        ready;
    logic [31:0] rdata;

    modport master (output req, we, addr, wdata, be, input ready, rdata);
    modport slave  (input req, we, addr, wdata, be, output ready, rdata);
endinterface

// File: rtl/mem_access.sv
// RV32I MEM stage plus MEM/WB register: sized loads/stores on a
// single-outstanding data port, stall while busy, abort after WAIT_LIMIT cycles.
module mem_access #(
    parameter int WAIT_LIMIT = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ex_valid,
    input  logic                ex_memread,
    input  logic                ex_memwrite,
    input  logic                ex_memtoreg,
    input  logic                ex_regwrite,
    input  logic [2:0]          ex_funct3,
    input  logic [31:0]         ex_aluresult,
    input  logic [31:0]         ex_rs2data,
    input  logic [4:0]          ex_rd,
    output logic                mem_stall,
    mem_access_if.master        dmem,
    output logic                wb_valid,
    output logic                wb_memtoreg,
    output logic                wb_regwrite,
    output logic [4:0]          wb_rd,
    output logic [31:0]         wb_readdata,
    output logic [31:0]         wb_aluresult,
    output logic                misalign_err,
    output logic                timeout_err
);
    typedef enum logic { S_IDLE, S_WAIT } state_t;

    state_t      state, state_n;
    logic [7:0]  cnt, cnt_n;
    logic        memop, f3_ok, align_ok, legal, illegal, abort, retire;
    logic [7:0]  lb;
    logic [15:0] lh;
    logic [31:0] load_data;

    assign memop = ex_valid & (ex_memread | ex_memwrite);

    // Stores only support B/H/W; the unsigned variants exist for loads only.
    assign f3_ok = (ex_funct3 inside {3'b000, 3'b001, 3'b010}) |
                   (ex_memread & (ex_funct3 inside {3'b100, 3'b101}));

    always_comb begin
        align_ok = 1'b1;
        case (ex_funct3[1:0])
            2'b01:   align_ok = ~ex_aluresult[0];
            2'b10:   align_ok = (ex_aluresult[1:0] == 2'b00);
            default: align_ok = 1'b1;
        endcase
    end

    assign legal   = memop & ~(ex_memread & ex_memwrite) & f3_ok & align_ok;
    assign illegal = memop & ~legal;

    assign dmem.req  = legal;
    assign dmem.we   = legal & ex_memwrite;
    assign dmem.addr = {ex_aluresult[31:2], 2'b00};

    always_comb begin
        dmem.wdata = ex_rs2data;
        dmem.be    = 4'b1111;
        if (ex_memwrite) begin
            case (ex_funct3[1:0])
                2'b00: begin
                    dmem.wdata = {4{ex_rs2data[7:0]}};
                    dmem.be    = 4'b0001 << ex_aluresult[1:0];
                end
                2'b01: begin
                    dmem.wdata = {2{ex_rs2data[15:0]}};
                    dmem.be    = 4'b0011 << {ex_aluresult[1], 1'b0};
                end
                default: ;
            endcase
        end
    end

    assign lb = dmem.rdata[8*ex_aluresult[1:0] +: 8];
    assign lh = ex_aluresult[1] ? dmem.rdata[31:16] : dmem.rdata[15:0];

    always_comb begin
        case (ex_funct3)
            3'b000:  load_data = {{24{lb[7]}}, lb};
            3'b001:  load_data = {{16{lh[15]}}, lh};
            3'b100:  load_data = {24'b0, lb};
            3'b101:  load_data = {16'b0, lh};
            default: load_data = dmem.rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= 8'd0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // cnt counts request cycles already spent; the WAIT_LIMIT-th one aborts.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        abort   = 1'b0;
        case (state)
            S_IDLE: begin
                if (legal & ~dmem.ready) begin
                    state_n = S_WAIT;
                    cnt_n   = 8'd1;
                end
            end
            S_WAIT: begin
                if (~legal | dmem.ready) begin
                    state_n = S_IDLE;
                    cnt_n   = 8'd0;
                end else if (cnt == 8'(WAIT_LIMIT - 1)) begin
                    abort   = 1'b1;
                    state_n = S_IDLE;
                    cnt_n   = 8'd0;
                end else begin
                    cnt_n = cnt + 8'd1;
                end
            end
            default: begin
                state_n = S_IDLE;
                cnt_n   = 8'd0;
            end
        endcase
    end

    assign mem_stall = legal & ~dmem.ready & ~abort;
    assign retire    = (ex_valid & ~ex_memread & ~ex_memwrite) | (legal & dmem.ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid     <= 1'b0;
            wb_memtoreg  <= 1'b0;
            wb_regwrite  <= 1'b0;
            wb_rd        <= 5'd0;
            wb_readdata  <= 32'd0;
            wb_aluresult <= 32'd0;
            misalign_err <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            wb_valid     <= retire;
            wb_memtoreg  <= retire & ex_memtoreg;
            wb_regwrite  <= retire & ex_regwrite;
            wb_rd        <= retire ? ex_rd : 5'd0;
            wb_readdata  <= (retire & ex_memread) ? load_data : 32'd0;
            wb_aluresult <= retire ? ex_aluresult : 32'd0;
            misalign_err <= illegal;
            timeout_err  <= abort;
        end
    end
endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: directed vector table, multi-cycle wait/abort/reset
// sequences, and random transactions checked against a behavioural model.
module tb_mem_access;
    localparam int WL = 4;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        ex_valid, ex_memread, ex_memwrite, ex_memtoreg, ex_regwrite;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_aluresult, ex_rs2data;
    logic [4:0]  ex_rd;
    logic        mem_stall, wb_valid, wb_memtoreg, wb_regwrite, misalign_err, timeout_err;
    logic [4:0]  wb_rd;
    logic [31:0] wb_readdata, wb_aluresult;

    mem_access_if dmem();

    mem_access #(.WAIT_LIMIT(WL)) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_valid(ex_valid), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
        .ex_memtoreg(ex_memtoreg), .ex_regwrite(ex_regwrite), .ex_funct3(ex_funct3),
        .ex_aluresult(ex_aluresult), .ex_rs2data(ex_rs2data), .ex_rd(ex_rd),
        .mem_stall(mem_stall), .dmem(dmem),
        .wb_valid(wb_valid), .wb_memtoreg(wb_memtoreg), .wb_regwrite(wb_regwrite),
        .wb_rd(wb_rd), .wb_readdata(wb_readdata), .wb_aluresult(wb_aluresult),
        .misalign_err(misalign_err), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int tests = 0, fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic r, input logic w, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] rs2, input logic [4:0] rdst);
        ex_valid = v; ex_memread = r; ex_memwrite = w;
        ex_memtoreg = r; ex_regwrite = ~w;
        ex_funct3 = f3; ex_aluresult = a; ex_rs2data = rs2; ex_rd = rdst;
    endtask

    // Reference model, derived from the access rules in plain arithmetic.
    function automatic bit m_legal(input bit v, input bit r, input bit w,
                                   input logic [2:0] f3, input logic [31:0] a);
        int unsigned size;
        if (!v || !(r || w) || (r && w)) return 1'b0;
        if (w && f3 > 3'd2) return 1'b0;
        case (f3)
            3'd0, 3'd4: size = 1;
            3'd1, 3'd5: size = 2;
            3'd2:       size = 4;
            default:    return 1'b0;
        endcase
        return (a % size) == 0;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] rdata);
        int unsigned b, h;
        b = (rdata >> (8 * (a % 4))) & 255;
        h = (rdata >> (16 * ((a / 2) % 2))) & 65535;
        case (f3)
            3'd0: return 32'((b >= 128) ? b - 256 : b);
            3'd4: return 32'(b);
            3'd1: return 32'((h >= 32768) ? h - 65536 : h);
            3'd5: return 32'(h);
            default: return rdata;
        endcase
    endfunction

    function automatic logic [3:0] m_be(input bit w, input logic [2:0] f3, input logic [31:0] a);
        if (!w) return 4'hF;
        case (f3)
            3'd0: return 4'(1 << (a % 4));
            3'd1: return 4'(3 << (2 * ((a / 2) % 2)));
            default: return 4'hF;
        endcase
    endfunction

    function automatic logic [31:0] m_wdata(input bit w, input logic [2:0] f3, input logic [31:0] rs2);
        if (!w) return rs2;
        case (f3)
            3'd0: return (rs2 & 32'hFF) * 32'h0101_0101;
            3'd1: return (rs2 & 32'hFFFF) * 32'h0001_0001;
            default: return rs2;
        endcase
    endfunction

    typedef struct {
        logic        v, r, w;
        logic [2:0]  f3;
        logic [31:0] a, rs2, rdata;
        logic        ereq;
        logic [3:0]  ebe;
        logic [31:0] ewdata;
        logic        ewb;
        logic [31:0] erd;
        logic        emis;
    } vec_t;

    vec_t tbl[$];

    initial begin
        int stalls, reqs;
        drive(0, 0, 0, 3'd0, 32'd0, 32'd0, 5'd0);
        dmem.ready = 1'b0;
        dmem.rdata = 32'd0;

        // v r w f3 addr rs2 rdata | req be wdata wb readdata mis
        tbl.push_back(vec_t'{1,1,0,3'd2,32'h100,32'h0,32'hDEADBEEF, 1,4'hF,32'h0,       1,32'hDEADBEEF,0});
        tbl.push_back(vec_t'{1,1,0,3'd0,32'h103,32'h0,32'h80FF1234, 1,4'hF,32'h0,       1,32'hFFFFFF80,0});
        tbl.push_back(vec_t'{1,1,0,3'd4,32'h103,32'h0,32'h80FF1234, 1,4'hF,32'h0,       1,32'h00000080,0});
        tbl.push_back(vec_t'{1,1,0,3'd1,32'h102,32'h0,32'h80FF1234, 1,4'hF,32'h0,       1,32'hFFFF80FF,0});
        tbl.push_back(vec_t'{1,1,0,3'd5,32'h102,32'h0,32'h80FF1234, 1,4'hF,32'h0,       1,32'h000080FF,0});
        tbl.push_back(vec_t'{1,0,1,3'd0,32'h201,32'hAB,32'h0,       1,4'h2,32'hABABABAB,1,32'h0,0});
        tbl.push_back(vec_t'{1,0,1,3'd1,32'h202,32'h1234,32'h0,     1,4'hC,32'h12341234,1,32'h0,0});
        tbl.push_back(vec_t'{1,0,1,3'd2,32'h204,32'hCAFEF00D,32'h0, 1,4'hF,32'hCAFEF00D,1,32'h0,0});
        tbl.push_back(vec_t'{1,1,0,3'd2,32'h102,32'h0,32'h11111111, 0,4'h0,32'h0,       0,32'h0,1});
        tbl.push_back(vec_t'{1,1,1,3'd2,32'h100,32'h0,32'h11111111, 0,4'h0,32'h0,       0,32'h0,1});
        tbl.push_back(vec_t'{1,1,0,3'd1,32'h101,32'h0,32'h11111111, 0,4'h0,32'h0,       0,32'h0,1});
        tbl.push_back(vec_t'{1,0,1,3'd4,32'h200,32'h55,32'h0,       0,4'h0,32'h0,       0,32'h0,1});
        tbl.push_back(vec_t'{1,1,0,3'd3,32'h100,32'h0,32'h11111111, 0,4'h0,32'h0,       0,32'h0,1});
        tbl.push_back(vec_t'{1,0,0,3'd0,32'h300,32'h0,32'h11111111, 0,4'h0,32'h0,       1,32'h0,0});
        tbl.push_back(vec_t'{0,1,0,3'd2,32'h100,32'h0,32'h11111111, 0,4'h0,32'h0,       0,32'h0,0});

        // Reset state
        #3;
        chk("rst wb_valid", 32'(wb_valid), 32'd0);
        chk("rst wb_readdata", wb_readdata, 32'd0);
        chk("rst misalign", 32'(misalign_err), 32'd0);
        chk("rst timeout", 32'(timeout_err), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        tick();

        foreach (tbl[i]) begin
            drive(tbl[i].v, tbl[i].r, tbl[i].w, tbl[i].f3, tbl[i].a, tbl[i].rs2, 5'(i + 1));
            dmem.ready = 1'b1;
            dmem.rdata = tbl[i].rdata;
            #1;
            chk($sformatf("vec%0d req", i), 32'(dmem.req), 32'(tbl[i].ereq));
            chk($sformatf("vec%0d stall", i), 32'(mem_stall), 32'd0);
            if (tbl[i].ereq) begin
                chk($sformatf("vec%0d be", i), 32'(dmem.be), 32'(tbl[i].ebe));
                chk($sformatf("vec%0d wdata", i), dmem.wdata, tbl[i].ewdata);
                chk($sformatf("vec%0d we", i), 32'(dmem.we), 32'(tbl[i].w));
                chk($sformatf("vec%0d addr", i), dmem.addr, tbl[i].a & 32'hFFFF_FFFC);
            end
            tick();
            chk($sformatf("vec%0d wb_valid", i), 32'(wb_valid), 32'(tbl[i].ewb));
            chk($sformatf("vec%0d wb_readdata", i), wb_readdata, tbl[i].erd);
            chk($sformatf("vec%0d misalign", i), 32'(misalign_err), 32'(tbl[i].emis));
            chk($sformatf("vec%0d wb_regwrite", i), 32'(wb_regwrite), 32'(tbl[i].ewb & ~tbl[i].w));
            chk($sformatf("vec%0d wb_memtoreg", i), 32'(wb_memtoreg), 32'(tbl[i].ewb & tbl[i].r));
            chk($sformatf("vec%0d wb_alu", i), wb_aluresult, tbl[i].ewb ? tbl[i].a : 32'd0);
        end

        // LW with ready after 3 wait cycles
        drive(1, 1, 0, 3'd2, 32'h100, 32'h0, 5'd7);
        dmem.rdata = 32'h12345678;
        stalls = 0;
        for (int i = 0; i < 4; i++) begin
            dmem.ready = (i == 3);
            #1;
            if (mem_stall) stalls++;
            if (i > 0) chk("wait wb_valid low", 32'(wb_valid), 32'd0);
            tick();
        end
        chk("wait stall cycles", 32'(stalls), 32'd3);
        chk("wait wb_valid", 32'(wb_valid), 32'd1);
        chk("wait wb_readdata", wb_readdata, 32'h12345678);
        drive(0, 0, 0, 3'd0, 32'd0, 32'd0, 5'd0);
        tick();
        chk("wait no duplicate", 32'(wb_valid), 32'd0);

        // Abort (ready never) then ready in the abort cycle
        for (int t = 0; t < 2; t++) begin
            drive(1, 1, 0, 3'd2, 32'h140, 32'h0, 5'd9);
            dmem.rdata = 32'hA5A5A5A5;
            reqs = 0; stalls = 0;
            for (int i = 0; i < 10; i++) begin
                dmem.ready = (t == 1) && (i == WL - 1);
                #1;
                if (dmem.req) reqs++;
                if (mem_stall) stalls++;
                if (!mem_stall) break;
                tick();
            end
            tick();
            chk($sformatf("abort%0d req cycles", t), 32'(reqs), 32'(WL));
            chk($sformatf("abort%0d stall cycles", t), 32'(stalls), 32'(WL - 1));
            chk($sformatf("abort%0d timeout", t), 32'(timeout_err), 32'(t == 0));
            chk($sformatf("abort%0d wb_valid", t), 32'(wb_valid), 32'(t == 1));
            drive(0, 0, 0, 3'd0, 32'd0, 32'd0, 5'd0);
            dmem.ready = 1'b0;
            tick();
            chk($sformatf("abort%0d timeout pulse", t), 32'(timeout_err), 32'd0);
        end

        // Asynchronous reset clears registered outputs immediately
        drive(1, 0, 0, 3'd0, 32'h44, 32'h0, 5'd3);
        tick();
        chk("async pre wb_valid", 32'(wb_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async wb_valid", 32'(wb_valid), 32'd0);
        chk("async wb_alu", wb_aluresult, 32'd0);
        @(negedge clk) rst_n = 1'b1;

        // Reset mid-WAIT drops the access; the retry gets a full wait budget
        drive(1, 1, 0, 3'd2, 32'h180, 32'h0, 5'd4);
        dmem.ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("midwait stall comb", 32'(mem_stall), 32'd1);
        chk("midwait wb_valid", 32'(wb_valid), 32'd0);
        chk("midwait timeout", 32'(timeout_err), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        #1;
        stalls = 0;
        for (int i = 0; i < 10; i++) begin
            if (!mem_stall) break;
            stalls++;
            tick();
        end
        chk("midwait fresh stalls", 32'(stalls), 32'(WL - 1));
        tick();
        chk("midwait timeout after retry", 32'(timeout_err), 32'd1);

        // Random transactions against the model
        for (int n = 0; n < 200; n++) begin
            int kind, k;
            bit v, r, w, lg, exp_stall, exp_wb;
            logic [2:0] f3;
            logic [31:0] a, rs2, rd_data;
            kind = $urandom_range(0, 9);
            v = (kind != 0);
            r = (kind >= 1 && kind <= 4) || kind == 9 || (kind == 0 && $urandom_range(0, 1) == 1);
            w = (kind >= 5 && kind <= 7) || kind == 9;
            f3 = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(0, 7)) :
                 (w ? 3'($urandom_range(0, 2)) : 3'(($urandom_range(0, 4) + 1) % 6 == 3 ? 4 : ($urandom_range(0, 4) + 1) % 6));
            a = 32'h1000 + $urandom_range(0, 255);
            rs2 = $urandom;
            rd_data = $urandom;
            k = $urandom_range(0, 5);
            drive(v, r, w, f3, a, rs2, 5'($urandom_range(1, 31)));
            lg = m_legal(v, r, w, f3, a);
            for (int i = 0; i < 10; i++) begin
                dmem.ready = (i >= k);
                dmem.rdata = (i >= k) ? rd_data : $urandom;
                #1;
                chk($sformatf("rnd%0d req", n), 32'(dmem.req), 32'(lg));
                if (i == 0 && lg) begin
                    chk($sformatf("rnd%0d be", n), 32'(dmem.be), 32'(m_be(w, f3, a)));
                    chk($sformatf("rnd%0d wdata", n), dmem.wdata, m_wdata(w, f3, rs2));
                end
                exp_stall = lg && (i < k) && (i < WL - 1);
                chk($sformatf("rnd%0d stall", n), 32'(mem_stall), 32'(exp_stall));
                if (!exp_stall) break;
                tick();
            end
            tick();
            exp_wb = (v && !r && !w) || (lg && k <= WL - 1);
            chk($sformatf("rnd%0d wb_valid", n), 32'(wb_valid), 32'(exp_wb));
            chk($sformatf("rnd%0d wb_readdata", n), wb_readdata,
                (exp_wb && r) ? m_load(f3, a, rd_data) : 32'd0);
            chk($sformatf("rnd%0d wb_rd", n), 32'(wb_rd), exp_wb ? 32'(ex_rd) : 32'd0);
            chk($sformatf("rnd%0d misalign", n), 32'(misalign_err), 32'(v && (r || w) && !lg));
            chk($sformatf("rnd%0d timeout", n), 32'(timeout_err), 32'(lg && k > WL - 1));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
